// File: rtl/gslcd_fb_pkg.sv
// Shared types and helpers for the GSLCD framebuffer read scheduler.
package gslcd_fb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } fb_state_e;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  function automatic int fb_bytes_per_burst(input int burst_len, input int data_width);
    return burst_len * data_width / 8;
  endfunction

  function automatic int fb_align_bits(input int burst_len, input int data_width);
    return $clog2(fb_bytes_per_burst(burst_len, data_width));
  endfunction

endpackage

// File: rtl/gslcd_fb_credit_ctr.sv
// Saturating FIFO credit counter: a burst reserves BURST_LEN words, each pop returns one.
module gslcd_fb_credit_ctr #(
  parameter int BURST_LEN  = 16,
  parameter int FIFO_DEPTH = 64,
  localparam int CW        = $clog2(FIFO_DEPTH) + 1
) (
  input  logic clk,
  input  logic reset,
  input  logic reserve,
  input  logic release_one,
  output logic has_burst_space
);

  logic [CW-1:0] credits_q, credits_d;
  logic [CW:0]   sum;

  // Clamped at both ends so stale traffic across a reset cannot wrap the count.
  always_comb begin
    sum = {1'b0, credits_q} + (CW+1)'(release_one);
    if (reserve)
      sum = (sum >= (CW+1)'(BURST_LEN)) ? sum - (CW+1)'(BURST_LEN) : '0;
    if (sum > (CW+1)'(FIFO_DEPTH))
      sum = (CW+1)'(FIFO_DEPTH);
    credits_d = CW'(sum);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) credits_q <= CW'(FIFO_DEPTH);
    else       credits_q <= credits_d;
  end

  assign has_burst_space = (credits_q >= CW'(BURST_LEN));

endmodule

// File: rtl/gslcd_fb_reader.sv
// Framebuffer burst read scheduler feeding the GSLCD pixel line FIFO.
// Define GSLCD_FB_READER_RRESP_CHECK_EN to flag non-OKAY read responses on err_resp.
module gslcd_fb_reader
  import gslcd_fb_pkg::*;
#(
  parameter int BURST_LEN       = 16,
  parameter int FIFO_DEPTH      = 64,
  parameter int MAX_OUTSTANDING = 4,
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  frame_start,
  input  logic [ADDR_WIDTH-1:0] fb_base,
  input  logic [19:0]           frame_bursts,
  input  logic                  fifo_pop,
  input  logic                  err_clear,
  output logic                  m_arvalid,
  input  logic                  m_arready,
  output logic [ADDR_WIDTH-1:0] m_araddr,
  output logic [7:0]            m_arlen,
  output logic [2:0]            m_arsize,
  output logic [1:0]            m_arburst,
  input  logic                  m_rvalid,
  output logic                  m_rready,
  input  logic [DATA_WIDTH-1:0] m_rdata,
  input  logic [1:0]            m_rresp,
  input  logic                  m_rlast,
  output logic                  fifo_push,
  output logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  err_overrun,
  output logic                  err_resp
);

  localparam int BYTES_PER_BURST = fb_bytes_per_burst(BURST_LEN, DATA_WIDTH);
  localparam int ALIGN_BITS      = fb_align_bits(BURST_LEN, DATA_WIDTH);
  localparam int OW              = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_STEP = ADDR_WIDTH'(BYTES_PER_BURST);
  localparam logic [ADDR_WIDTH-1:0] LOW_MASK  = ADDR_WIDTH'((64'd1 << ALIGN_BITS) - 64'd1);

  fb_state_e             state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [19:0]           remaining_q, remaining_d;
  logic [OW-1:0]         outstanding_q, outstanding_d;
  logic                  arvalid_q, arvalid_d;
  logic                  push_q, push_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  frame_done_q, frame_done_d;
  logic                  err_overrun_q, err_overrun_d;
  logic                  err_resp_q, err_resp_d;

  logic ar_hs, r_hs, r_done, has_space, can_issue, start_ok;

  assign ar_hs     = arvalid_q & m_arready;
  assign r_hs      = m_rvalid & m_rready;
  assign r_done    = r_hs & m_rlast;
  assign can_issue = enable & has_space & (outstanding_q < OW'(MAX_OUTSTANDING));
  assign start_ok  = (state_q == ST_IDLE) & frame_start & enable;

  gslcd_fb_credit_ctr #(
    .BURST_LEN (BURST_LEN),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_credit (
    .clk            (clk),
    .reset          (reset),
    .reserve        (ar_hs),
    .release_one    (fifo_pop),
    .has_burst_space(has_space)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start_ok && frame_bursts != '0) state_d = ST_ISSUE;
      ST_ISSUE: if ((ar_hs && remaining_q == 20'd1) || remaining_q == '0 ||
                    (!enable && !arvalid_q))        state_d = ST_DRAIN;
      ST_DRAIN: if (outstanding_q == '0)            state_d = ST_IDLE;
      default:                                      state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    addr_d        = addr_q;
    remaining_d   = remaining_q;
    outstanding_d = outstanding_q;
    arvalid_d     = arvalid_q;
    frame_done_d  = 1'b0;
    push_d        = r_hs;
    data_d        = r_hs ? m_rdata : data_q;
    err_overrun_d = (err_overrun_q & ~err_clear) | (frame_start & (state_q != ST_IDLE));

    if (start_ok) begin
      addr_d       = fb_base & ~LOW_MASK;
      remaining_d  = frame_bursts;
      frame_done_d = (frame_bursts == '0);
    end
    if (state_q == ST_DRAIN && outstanding_q == '0)
      frame_done_d = 1'b1;

    // A raised request is only ever dropped by its handshake, never by enable.
    if (ar_hs) begin
      addr_d      = addr_q + ADDR_STEP;
      remaining_d = remaining_q - 20'd1;
      arvalid_d   = 1'b0;
    end else if (!arvalid_q) begin
      arvalid_d = can_issue &
                  ((start_ok && frame_bursts != '0) ||
                   (state_q == ST_ISSUE && remaining_q != '0));
    end

    case ({ar_hs, r_done})
      2'b10:   outstanding_d = outstanding_q + OW'(1);
      2'b01:   outstanding_d = (outstanding_q == '0) ? '0 : outstanding_q - OW'(1);
      default: outstanding_d = outstanding_q;
    endcase

`ifdef GSLCD_FB_READER_RRESP_CHECK_EN
    err_resp_d = (err_resp_q & ~err_clear) | (r_hs & (m_rresp != AXI_RESP_OKAY));
`else
    err_resp_d = 1'b0;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q        <= '0;
      remaining_q   <= '0;
      outstanding_q <= '0;
      arvalid_q     <= 1'b0;
      push_q        <= 1'b0;
      data_q        <= '0;
      frame_done_q  <= 1'b0;
      err_overrun_q <= 1'b0;
      err_resp_q    <= 1'b0;
    end else begin
      addr_q        <= addr_d;
      remaining_q   <= remaining_d;
      outstanding_q <= outstanding_d;
      arvalid_q     <= arvalid_d;
      push_q        <= push_d;
      data_q        <= data_d;
      frame_done_q  <= frame_done_d;
      err_overrun_q <= err_overrun_d;
      err_resp_q    <= err_resp_d;
    end
  end

`ifndef GSLCD_FB_READER_RRESP_CHECK_EN
  logic unused_rresp;
  assign unused_rresp = ^m_rresp;
`endif

  assign m_arvalid   = arvalid_q;
  assign m_araddr    = addr_q;
  assign m_arlen     = 8'(BURST_LEN - 1);
  assign m_arsize    = 3'($clog2(DATA_WIDTH / 8));
  assign m_arburst   = AXI_BURST_INCR;
  assign m_rready    = ~reset;
  assign fifo_push   = push_q;
  assign fifo_data   = data_q;
  assign busy        = (state_q != ST_IDLE);
  assign frame_done  = frame_done_q;
  assign err_overrun = err_overrun_q;
  assign err_resp    = err_resp_q;

endmodule

// File: tb/tb_gslcd_fb_reader.sv
// Directed bench for gslcd_fb_reader: frame table plus hand-written corner sequences.
module tb_gslcd_fb_reader;

  logic        clk = 1'b0;
  logic        reset, enable, frame_start, fifo_pop, err_clear;
  logic [31:0] fb_base;
  logic [19:0] frame_bursts;
  logic        m_arvalid, m_arready, m_rvalid, m_rready, m_rlast;
  logic [31:0] m_araddr, m_rdata, fifo_data;
  logic [7:0]  m_arlen;
  logic [2:0]  m_arsize;
  logic [1:0]  m_arburst, m_rresp;
  logic        fifo_push, busy, frame_done, err_overrun, err_resp;

  always #5 clk = ~clk;

  gslcd_fb_reader dut (
    .clk(clk), .reset(reset), .enable(enable), .frame_start(frame_start),
    .fb_base(fb_base), .frame_bursts(frame_bursts), .fifo_pop(fifo_pop),
    .err_clear(err_clear), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize),
    .m_arburst(m_arburst), .m_rvalid(m_rvalid), .m_rready(m_rready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast),
    .fifo_push(fifo_push), .fifo_data(fifo_data), .busy(busy),
    .frame_done(frame_done), .err_overrun(err_overrun), .err_resp(err_resp)
  );

`ifdef GSLCD_FB_READER_RRESP_CHECK_EN
  localparam logic RESP_EXP = 1'b1;
`else
  localparam logic RESP_EXP = 1'b0;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  // slave / FIFO model knobs and observations
  logic        ar_en = 1'b1;
  int          r_budget = 0, pop_budget = 0, bad_beat = 0;
  int          ar_cnt = 0, push_cnt = 0, done_cnt = 0, data_bad = 0, hdr_bad = 0, lvl = 0;
  logic [31:0] dseed = 32'hA500_0000;
  logic [31:0] ar_addrs[$];
  logic [31:0] sb[$];
  int          pend[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // AXI slave, FIFO drain and output monitor; everything happens on the falling edge.
  initial begin
    logic [31:0] w;
    int beat;
    m_arready = 1'b0; m_rvalid = 1'b0; m_rlast = 1'b0; m_rresp = 2'b00;
    m_rdata = '0; fifo_pop = 1'b0;
    forever begin
      @(negedge clk);
      if (fifo_push) begin
        push_cnt++;
        lvl++;
        if (sb.size() == 0) data_bad++;
        else begin
          w = sb.pop_front();
          if (fifo_data !== w) data_bad++;
        end
      end
      if (frame_done) done_cnt++;
      if (pop_budget > 0 && lvl > 0) begin
        fifo_pop = 1'b1; lvl--; pop_budget--;
      end else fifo_pop = 1'b0;
      m_rvalid = 1'b0; m_rlast = 1'b0; m_rresp = 2'b00;
      if (!reset && r_budget > 0 && pend.size() > 0) begin
        if (!m_rready) hdr_bad++;
        beat     = 17 - pend[0];
        m_rvalid = 1'b1;
        m_rdata  = dseed;
        dseed    = dseed + 32'd1;
        m_rresp  = (beat == bad_beat) ? 2'b10 : 2'b00;
        m_rlast  = (pend[0] == 1);
        sb.push_back(m_rdata);
        pend[0]  = pend[0] - 1;
        if (pend[0] == 0) beat = pend.pop_front();
        r_budget--;
      end
      m_arready = ar_en;
      if (!reset && m_arvalid && m_arready) begin
        ar_cnt++;
        ar_addrs.push_back(m_araddr);
        if (m_arlen != 8'd15 || m_arsize != 3'd2 || m_arburst != 2'b01) hdr_bad++;
        pend.push_back(16);
      end
    end
  end

  task automatic start_frame(input logic [31:0] base, input logic [19:0] nb,
                             output logic av, output logic fd);
    @(negedge clk);
    fb_base = base; frame_bursts = nb; frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    av = m_arvalid;
    fd = frame_done;
  endtask

  task automatic wait_done(input int d0, input string nm);
    int k = 0;
    while (done_cnt == d0 && k < 3000) begin
      @(negedge clk);
      k++;
    end
    chk(nm, 64'(done_cnt != d0), 64'd1);
    repeat (10) @(negedge clk);
  endtask

  task automatic pulse_clear();
    @(negedge clk); err_clear = 1'b1;
    @(negedge clk); err_clear = 1'b0;
  endtask

  typedef struct {
    logic [31:0] base;
    logic [19:0] bursts;
    logic        exp_av;
    logic        exp_fd;
    int          exp_ars;
    logic [31:0] exp_first;
    logic [31:0] exp_last;
  } vec_t;

  vec_t vt[5];

  initial begin
    logic av, fd;
    int a0, p0, d0, q0;
    vt[0] = '{32'h1000_0000, 20'd3, 1'b1, 1'b0, 3, 32'h1000_0000, 32'h1000_0080};
    vt[1] = '{32'h2000_0025, 20'd2, 1'b1, 1'b0, 2, 32'h2000_0000, 32'h2000_0040};
    vt[2] = '{32'hFFFF_FFC0, 20'd2, 1'b1, 1'b0, 2, 32'hFFFF_FFC0, 32'h0000_0000};
    vt[3] = '{32'h0000_1234, 20'd5, 1'b1, 1'b0, 5, 32'h0000_1200, 32'h0000_1300};
    vt[4] = '{32'h3000_0000, 20'd0, 1'b0, 1'b1, 0, 32'h0,         32'h0};

    reset = 1'b1; enable = 1'b1; frame_start = 1'b0; err_clear = 1'b0;
    fb_base = '0; frame_bursts = '0;
    repeat (3) @(negedge clk);
    chk("rst_arvalid", 64'(m_arvalid), 64'd0);
    chk("rst_araddr", 64'(m_araddr), 64'd0);
    chk("rst_rready", 64'(m_rready), 64'd0);
    chk("rst_flags", 64'({fifo_push, busy, frame_done, err_overrun, err_resp}), 64'd0);
    chk("const_ar", 64'({m_arlen, m_arsize, m_arburst}), 64'({8'd15, 3'd2, 2'b01}));
    reset = 1'b0;
    @(negedge clk);
    chk("rready_after_rst", 64'(m_rready), 64'd1);

    // table-driven frames with free-running slave and consumer
    r_budget = 1_000_000; pop_budget = 1_000_000;
    for (int i = 0; i < 5; i++) begin
      a0 = ar_cnt; p0 = push_cnt; d0 = done_cnt; q0 = ar_addrs.size();
      start_frame(vt[i].base, vt[i].bursts, av, fd);
      chk($sformatf("v%0d_arvalid_n1", i), 64'(av), 64'(vt[i].exp_av));
      chk($sformatf("v%0d_done_n1", i), 64'(fd), 64'(vt[i].exp_fd));
      wait_done(d0, $sformatf("v%0d_done_seen", i));
      chk($sformatf("v%0d_ar_count", i), 64'(ar_cnt - a0), 64'(vt[i].exp_ars));
      chk($sformatf("v%0d_push_count", i), 64'(push_cnt - p0), 64'(vt[i].exp_ars * 16));
      chk($sformatf("v%0d_done_count", i), 64'(done_cnt - d0), 64'd1);
      chk($sformatf("v%0d_busy", i), 64'(busy), 64'd0);
      if (vt[i].exp_ars > 0 && ar_addrs.size() > q0) begin
        chk($sformatf("v%0d_first_addr", i), 64'(ar_addrs[q0]), 64'(vt[i].exp_first));
        chk($sformatf("v%0d_last_addr", i), 64'(ar_addrs[ar_addrs.size()-1]), 64'(vt[i].exp_last));
      end
    end

    // credit stall: no consumer, 8 bursts -> 4 issued; 16 pops -> one more
    pop_budget = 0; a0 = ar_cnt; d0 = done_cnt;
    start_frame(32'h4000_0000, 20'd8, av, fd);
    repeat (100) @(negedge clk);
    chk("credit_stall_ars", 64'(ar_cnt - a0), 64'd4);
    chk("credit_stall_arvalid", 64'(m_arvalid), 64'd0);
    chk("credit_stall_busy", 64'(busy), 64'd1);
    pop_budget = 16;
    repeat (100) @(negedge clk);
    chk("credit_16pop_ars", 64'(ar_cnt - a0), 64'd5);
    pop_budget = 1_000_000;
    wait_done(d0, "credit_done_seen");
    chk("credit_total_ars", 64'(ar_cnt - a0), 64'd8);

    // outstanding limit: withhold R, release exactly one burst
    r_budget = 0; a0 = ar_cnt; d0 = done_cnt;
    start_frame(32'h4800_0000, 20'd6, av, fd);
    repeat (60) @(negedge clk);
    chk("outst_stall_ars", 64'(ar_cnt - a0), 64'd4);
    r_budget = 16;
    repeat (60) @(negedge clk);
    chk("outst_one_rlast_ars", 64'(ar_cnt - a0), 64'd5);
    r_budget = 1_000_000;
    wait_done(d0, "outst_done_seen");
    chk("outst_total_ars", 64'(ar_cnt - a0), 64'd6);

    // overrun while busy; err_clear alone clears, err_clear with a new error keeps it
    ar_en = 1'b0; a0 = ar_cnt; d0 = done_cnt; q0 = ar_addrs.size();
    start_frame(32'h6000_0010, 20'd2, av, fd);
    start_frame(32'h7000_0000, 20'd9, av, fd);
    chk("overrun_set", 64'(err_overrun), 64'd1);
    chk("overrun_addr_kept", 64'(m_araddr), 64'h6000_0000);
    pulse_clear();
    chk("overrun_cleared", 64'(err_overrun), 64'd0);
    @(negedge clk); err_clear = 1'b1; frame_start = 1'b1;
    @(negedge clk); err_clear = 1'b0; frame_start = 1'b0;
    chk("overrun_wins_clear", 64'(err_overrun), 64'd1);
    pulse_clear();
    ar_en = 1'b1;
    wait_done(d0, "overrun_done_seen");
    chk("overrun_frame_ars", 64'(ar_cnt - a0), 64'd2);
    if (ar_addrs.size() > q0) chk("overrun_frame_base", 64'(ar_addrs[q0]), 64'h6000_0000);

    // enable drop with a pending request
    ar_en = 1'b0; a0 = ar_cnt; d0 = done_cnt;
    start_frame(32'h5000_0000, 20'd4, av, fd);
    enable = 1'b0;
    repeat (5) @(negedge clk);
    chk("endrop_held_valid", 64'(m_arvalid), 64'd1);
    chk("endrop_held_addr", 64'(m_araddr), 64'h5000_0000);
    ar_en = 1'b1;
    wait_done(d0, "endrop_done_seen");
    chk("endrop_ars", 64'(ar_cnt - a0), 64'd1);
    chk("endrop_done_count", 64'(done_cnt - d0), 64'd1);
    chk("endrop_busy", 64'(busy), 64'd0);
    enable = 1'b1;

    // response error on beat 5
    bad_beat = 5; p0 = push_cnt; d0 = done_cnt;
    start_frame(32'h5800_0000, 20'd1, av, fd);
    wait_done(d0, "resp_done_seen");
    bad_beat = 0;
    chk("resp_err_flag", 64'(err_resp), 64'(RESP_EXP));
    chk("resp_pushes", 64'(push_cnt - p0), 64'd16);
    pulse_clear();
    chk("resp_err_cleared", 64'(err_resp), 64'd0);

    // reset mid-frame with bursts in flight; stale beats must not wedge the next frame
    r_budget = 0; p0 = push_cnt;
    start_frame(32'h9000_0000, 20'd6, av, fd);
    repeat (30) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_arvalid_addr", 64'({m_arvalid, m_araddr}), 64'd0);
    chk("midrst_rready", 64'(m_rready), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    r_budget = 1_000_000;
    repeat (150) @(negedge clk);
    chk("midrst_stale_pushed", 64'(push_cnt - p0), 64'd64);
    chk("midrst_idle", 64'(busy), 64'd0);
    a0 = ar_cnt; d0 = done_cnt;
    start_frame(32'h8000_0000, 20'd2, av, fd);
    chk("postrst_arvalid_n1", 64'(av), 64'd1);
    wait_done(d0, "postrst_done_seen");
    chk("postrst_ars", 64'(ar_cnt - a0), 64'd2);

    chk("data_order", 64'(data_bad), 64'd0);
    chk("ar_hdr_rready", 64'(hdr_bad), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
